// File: rtl/parallel_in_shift_register.sv
// Parallel-in, serial-out transmitter: accepts one WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per ShiftEn edge, MSB or LSB first.
module parallel_in_shift_register #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] ParallelIn,
    input  logic             LoadValid,
    output logic             LoadReady,
    input  logic             ShiftEn,
    output logic             ShiftOut,
    output logic             ShiftValid,
    output logic             Busy,
    output logic             Done
);
    // state    | meaning
    // ST_IDLE  | waiting for a word; LoadReady high, sreg held at zero so ShiftOut is low
    // ST_SHIFT | serializing sreg, one bit per edge with ShiftEn high

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    localparam int               CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    logic             state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_shifted;
    logic [CW-1:0]    cnt;
    logic             done_q;

    // The output bit is a direct register tap; sreg is cleared on word end so IDLE drives 0.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
            assign ShiftOut     = sreg[WIDTH-1];
        end else begin : g_lsb_first
            assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
            assign ShiftOut     = sreg[0];
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (LoadValid) begin
                        sreg  <= ParallelIn;
                        cnt   <= '0;
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ShiftEn) begin
                        if (cnt == LAST_CNT) begin
                            sreg   <= '0;
                            cnt    <= '0;
                            done_q <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            sreg <= sreg_shifted;
                            cnt  <= cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    sreg  <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign LoadReady  = (state == ST_IDLE);
    assign Busy       = (state == ST_SHIFT);
    assign ShiftValid = (state == ST_SHIFT);
    assign Done       = done_q;

endmodule

// File: tb/tb_parallel_in_shift_register.sv
// Bench for parallel_in_shift_register: expected serial bits are queued at load time
// and popped as the transmitter advances; a small receiver checks the loopback word.
module tb_parallel_in_shift_register;
    logic       Clk = 1'b0;
    logic       Reset;
    logic       ShiftEn;
    logic [3:0] ParallelIn;
    logic       lv_m, lv_l;
    logic       lr_m, so_m, sv_m, busy_m, done_m;
    logic       lr_l, so_l, sv_l, busy_l, done_l;
    logic [3:0] rx;

    int n_cmp = 0;
    int n_bad = 0;
    bit exp_q[$];

    always #5 Clk = ~Clk;

    parallel_in_shift_register #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .Clk(Clk), .Reset(Reset), .ParallelIn(ParallelIn), .LoadValid(lv_m),
        .LoadReady(lr_m), .ShiftEn(ShiftEn), .ShiftOut(so_m), .ShiftValid(sv_m),
        .Busy(busy_m), .Done(done_m)
    );

    parallel_in_shift_register #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .Clk(Clk), .Reset(Reset), .ParallelIn(ParallelIn), .LoadValid(lv_l),
        .LoadReady(lr_l), .ShiftEn(ShiftEn), .ShiftOut(so_l), .ShiftValid(sv_l),
        .Busy(busy_l), .Done(done_l)
    );

    // Serial-in, parallel-out receiver sharing ShiftEn with the transmitter.
    always @(posedge Clk) begin
        if (Reset) rx <= 4'b0000;
        else if (ShiftEn) rx <= {rx[2:0], so_m};
    end

    function automatic void push_word(input logic [3:0] w, input bit msb);
        for (int i = 0; i < 4; i++) exp_q.push_back(msb ? w[3-i] : w[i]);
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; lv_m = 1'b0; lv_l = 1'b0; ShiftEn = 1'b0; ParallelIn = 4'b0000;
        tick(); tick();
        n_cmp++;
        if ({lr_m, busy_m, sv_m, so_m, done_m} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_msb: got %b want 10000", {lr_m, busy_m, sv_m, so_m, done_m});
        end
        n_cmp++;
        if ({lr_l, busy_l, sv_l, so_l, done_l} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_lsb: got %b want 10000", {lr_l, busy_l, sv_l, so_l, done_l});
        end
        Reset = 1'b0; ShiftEn = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({lr_m, busy_m, sv_m, so_m, done_m} !== 5'b10000) begin
                n_bad++; $display("FAIL idle_ignores_shiften: got %b want 10000", {lr_m, busy_m, sv_m, so_m, done_m});
            end
        end
        ShiftEn = 1'b0;
    endtask

    task automatic test_msb_first();
        exp_q.delete();
        ParallelIn = 4'b1011; lv_m = 1'b1; ShiftEn = 1'b1;
        push_word(4'b1011, 1'b1);
        tick();
        lv_m = 1'b0; ParallelIn = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            logic eb;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            n_cmp++;
            if ({sv_m, lr_m, busy_m, done_m, so_m} !== {4'b1010, eb}) begin
                n_bad++; $display("FAIL msb_bit%0d: got sv/lr/busy/done/so=%b want %b", i, {sv_m, lr_m, busy_m, done_m, so_m}, {4'b1010, eb});
            end
            tick();
        end
        n_cmp++;
        if ({done_m, lr_m, so_m, sv_m} !== 4'b1100) begin
            n_bad++; $display("FAIL msb_done: got done/lr/so/sv=%b want 1100", {done_m, lr_m, so_m, sv_m});
        end
        ShiftEn = 1'b0;
        tick();
        n_cmp++;
        if (done_m !== 1'b0) begin
            n_bad++; $display("FAIL msb_done_width: got %b want 0", done_m);
        end
    endtask

    task automatic test_lsb_first();
        int dones;
        exp_q.delete();
        ParallelIn = 4'b1011; lv_l = 1'b1; ShiftEn = 1'b1;
        push_word(4'b1011, 1'b0);
        tick();
        lv_l = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic eb;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            n_cmp++;
            if ({sv_l, so_l} !== {1'b1, eb}) begin
                n_bad++; $display("FAIL lsb_bit%0d: got sv/so=%b want %b", i, {sv_l, so_l}, {1'b1, eb});
            end
            tick();
        end
        n_cmp++;
        if (done_l !== 1'b1) begin
            n_bad++; $display("FAIL lsb_done: got %b want 1", done_l);
        end
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            if (done_l === 1'b1) dones++;
            tick();
        end
        n_cmp++;
        if (dones != 1) begin
            n_bad++; $display("FAIL lsb_done_count: got %0d want 1", dones);
        end
        ShiftEn = 1'b0;
    endtask

    task automatic test_stall();
        exp_q.delete();
        ParallelIn = 4'b1100; lv_m = 1'b1; ShiftEn = 1'b1;
        push_word(4'b1100, 1'b1);
        tick();
        lv_m = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic eb;
            logic se;
            eb = (exp_q.size() > 0) ? exp_q[0] : 1'b0;
            n_cmp++;
            if ({sv_m, done_m, so_m} !== {2'b10, eb}) begin
                n_bad++; $display("FAIL stall_cycle%0d: got sv/done/so=%b want %b", k, {sv_m, done_m, so_m}, {2'b10, eb});
            end
            se = (k % 2 == 1);
            ShiftEn = se;
            if (se && exp_q.size() > 0) void'(exp_q.pop_front());
            tick();
        end
        n_cmp++;
        if ({done_m, lr_m} !== 2'b11) begin
            n_bad++; $display("FAIL stall_done: got done/lr=%b want 11", {done_m, lr_m});
        end
        ShiftEn = 1'b0;
        tick();
    endtask

    task automatic test_ignored_load();
        exp_q.delete();
        ParallelIn = 4'b1001; lv_m = 1'b1; ShiftEn = 1'b1;
        push_word(4'b1001, 1'b1);
        tick();
        ParallelIn = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            logic eb;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            n_cmp++;
            if ({lr_m, sv_m, so_m} !== {2'b01, eb}) begin
                n_bad++; $display("FAIL ignored_load_bit%0d: got lr/sv/so=%b want %b", i, {lr_m, sv_m, so_m}, {2'b01, eb});
            end
            tick();
        end
        n_cmp++;
        if ({done_m, lr_m} !== 2'b11) begin
            n_bad++; $display("FAIL ignored_load_done: got done/lr=%b want 11", {done_m, lr_m});
        end
        push_word(4'b0110, 1'b1);
        tick();
        lv_m = 1'b0; ParallelIn = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            logic eb;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            n_cmp++;
            if ({sv_m, so_m} !== {1'b1, eb}) begin
                n_bad++; $display("FAIL back_to_back_bit%0d: got sv/so=%b want %b", i, {sv_m, so_m}, {1'b1, eb});
            end
            tick();
        end
        n_cmp++;
        if (done_m !== 1'b1) begin
            n_bad++; $display("FAIL back_to_back_done: got %b want 1", done_m);
        end
        ShiftEn = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        exp_q.delete();
        ParallelIn = 4'b1111; lv_m = 1'b1; ShiftEn = 1'b1;
        tick();
        lv_m = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if ({sv_m, so_m} !== 2'b11) begin
                n_bad++; $display("FAIL mid_reset_bit%0d: got sv/so=%b want 11", i, {sv_m, so_m});
            end
            tick();
        end
        // Reset together with a load request: reset must win.
        Reset = 1'b1; lv_m = 1'b1; ParallelIn = 4'b1010;
        tick();
        n_cmp++;
        if ({lr_m, busy_m, sv_m, so_m, done_m} !== 5'b10000) begin
            n_bad++; $display("FAIL mid_reset_idle: got %b want 10000", {lr_m, busy_m, sv_m, so_m, done_m});
        end
        Reset = 1'b0; lv_m = 1'b0;
        tick();
        n_cmp++;
        if ({busy_m, done_m} !== 2'b00) begin
            n_bad++; $display("FAIL mid_reset_no_done: got busy/done=%b want 00", {busy_m, done_m});
        end
        ParallelIn = 4'b0101; lv_m = 1'b1;
        push_word(4'b0101, 1'b1);
        tick();
        lv_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            logic eb;
            eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
            n_cmp++;
            if ({sv_m, so_m} !== {1'b1, eb}) begin
                n_bad++; $display("FAIL after_reset_bit%0d: got sv/so=%b want %b", i, {sv_m, so_m}, {1'b1, eb});
            end
            tick();
        end
        n_cmp++;
        if (done_m !== 1'b1) begin
            n_bad++; $display("FAIL after_reset_done: got %b want 1", done_m);
        end
        ShiftEn = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        ShiftEn = 1'b0; ParallelIn = 4'b1011; lv_m = 1'b1;
        tick();
        lv_m = 1'b0; ShiftEn = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ShiftEn = 1'b0;
        n_cmp++;
        if (rx !== 4'b1011) begin
            n_bad++; $display("FAIL loopback_word: got %b want 1011", rx);
        end
        n_cmp++;
        if (done_m !== 1'b1) begin
            n_bad++; $display("FAIL loopback_done: got %b want 1", done_m);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall();
        test_ignored_load();
        test_mid_reset();
        test_loopback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
